// File: rtl/prio_enc_hs_if.sv
// prio_enc_hs_if: request/grant handshake bundle; slave = encoder side (en_n, req, ready in; y, valid, none out), master = producer/consumer side
interface prio_enc_hs_if #(parameter int N = 8);
  localparam int W = $clog2(N);
  logic         en_n;
  logic [N-1:0] req;
  logic [W-1:0] y;
  logic         valid;
  logic         ready;
  logic         none;
  modport slave (input en_n, req, ready, output y, valid, none);
  modport master (output en_n, req, ready, input y, valid, none);
endinterface

// File: rtl/prio_enc_hs.sv
// prio_enc_hs: sticky N-to-log2(N) priority/round-robin encoder with registered valid/ready output; ports clk, rst (sync, active-high), bus (en_n, req, ready in; y, valid, none out)
module prio_enc_hs #(
  parameter int N = 8,
  parameter int W = $clog2(N),
  parameter int MODE = 0
) (
  input logic clk,
  input logic rst,
  prio_enc_hs_if.slave bus
);
  logic [N-1:0] pend, take;
  logic [W-1:0] ptr, sel, y_q;
  logic valid_q, ld, found;
  int k;
  always_comb begin
    sel = '0;
    found = 1'b0;
    k = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (pend[i]) sel = W'(i);
    end else begin
      for (int j = 0; j < N; j++) begin
        k = int'(ptr) + j;
        k = (k >= N) ? k - N : k;
        if (!found && pend[k]) begin
          sel = W'(k);
          found = 1'b1;
        end
      end
    end
  end
  assign ld = !valid_q || bus.ready;
  assign take = (ld && |pend) ? (N'(1) << sel) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      valid_q <= 1'b0;
      y_q <= '0;
      ptr <= '0;
    end else begin
      pend <= (pend & ~take) | (bus.en_n ? '0 : bus.req);
      if (ld) begin
        valid_q <= |pend;
        if (|pend) begin
          y_q <= sel;
          ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
        end
      end
    end
  end
  assign bus.y = y_q;
  assign bus.valid = valid_q;
  assign bus.none = ~|pend && !valid_q;
endmodule

// File: tb/tb_prio_enc_hs.sv
// tb_prio_enc_hs: directed checks of fixed-priority (d0) and round-robin (d1) encoders driven by shared stimulus
module tb_prio_enc_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_n = 1'b1;
  logic [7:0] req = '0;
  logic ready = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  prio_enc_hs_if #(.N(8)) b0 ();
  prio_enc_hs_if #(.N(8)) b1 ();
  assign b0.en_n = en_n;
  assign b0.req = req;
  assign b0.ready = ready;
  assign b1.en_n = en_n;
  assign b1.req = req;
  assign b1.ready = ready;
  prio_enc_hs #(.N(8), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  prio_enc_hs #(.N(8), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en_n = 1'b1;
    req = '0;
    ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_valid", 32'(b0.valid), 0);
    chk("rst_y", 32'(b0.y), 0);
    chk("rst_none", 32'(b0.none), 1);
    chk("rst_none_rr", 32'(b1.none), 1);
    en_n = 1'b0; req = 8'h05; ready = 1'b1;
    tick();
    chk("t1_cap_valid", 32'(b0.valid), 0);
    chk("t1_cap_none", 32'(b0.none), 0);
    req = '0;
    tick();
    chk("t1_y2", {b0.valid, 5'd0, b0.y}, 32'h102);
    tick();
    chk("t1_y0", {b0.valid, 5'd0, b0.y}, 32'h100);
    tick();
    chk("t1_idle_valid", 32'(b0.valid), 0);
    chk("t1_idle_none", 32'(b0.none), 1);
    en_n = 1'b1; req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid", 32'(b0.valid), 0);
      chk("t2_none", 32'(b0.none), 1);
      chk("t2_none_rr", 32'(b1.none), 1);
    end
    do_reset();
    en_n = 1'b0; req = 8'h08; ready = 1'b0;
    tick();
    req = '0;
    tick();
    chk("t3_y3", {b0.valid, 5'd0, b0.y}, 32'h103);
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 8'h80 : 8'h00;
      tick();
      chk("t3_hold", {b0.valid, 5'd0, b0.y}, 32'h103);
    end
    req = '0; ready = 1'b1;
    tick();
    chk("t3_y7", {b0.valid, 5'd0, b0.y}, 32'h107);
    tick();
    chk("t3_drained", 32'(b0.none), 1);
    do_reset();
    en_n = 1'b0; req = 8'h81; ready = 1'b1;
    tick();
    tick();
    chk("t4_rr_g0", {b1.valid, 5'd0, b1.y}, 32'h100);
    chk("t4_fp_g0", {b0.valid, 5'd0, b0.y}, 32'h107);
    tick();
    chk("t4_rr_g1", {b1.valid, 5'd0, b1.y}, 32'h107);
    tick();
    chk("t4_rr_wrap", {b1.valid, 5'd0, b1.y}, 32'h100);
    tick();
    chk("t4_rr_g3", {b1.valid, 5'd0, b1.y}, 32'h107);
    chk("t4_fp_g3", {b0.valid, 5'd0, b0.y}, 32'h107);
    do_reset();
    en_n = 1'b0; req = 8'h10; ready = 1'b1;
    tick();
    tick();
    chk("t5_first", {b0.valid, 5'd0, b0.y}, 32'h104);
    req = '0;
    tick();
    chk("t5_second", {b0.valid, 5'd0, b0.y}, 32'h104);
    tick();
    chk("t5_done_valid", 32'(b0.valid), 0);
    chk("t5_done_none", 32'(b0.none), 1);
    do_reset();
    en_n = 1'b0; req = 8'hF0; ready = 1'b0;
    tick();
    tick();
    chk("t6_pre", {b0.valid, 5'd0, b0.y}, 32'h107);
    chk("t6_pre_none", 32'(b0.none), 0);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; ready = 1'b1;
    chk("t6_rst_valid", 32'(b0.valid), 0);
    chk("t6_rst_y", 32'(b0.y), 0);
    chk("t6_rst_none", 32'(b0.none), 1);
    tick();
    chk("t6_no_stale", 32'(b0.valid), 0);
    chk("t6_no_stale_rr", 32'(b1.valid), 0);
    tick();
    chk("t6_still_idle", 32'(b0.none), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
